// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StExec  = 2'd2,
      StHalt  = 2'd3
   } state_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int unsigned DEF_PC_STEP  = 4;

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// Program-counter register: async active-low clear to a reset value, plus a load enable.
module pc_reg #(
   parameter int unsigned       WIDTH     = 32,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute sequencer owning the PC; next PC is halt > jump > branch > step.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned         ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(DEF_RESET_PC),
   parameter int unsigned         PC_STEP  = DEF_PC_STEP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [ADDR_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] instr,
   output logic              instr_valid,
   input  logic              exec_done,
   input  logic              halt_req,
   input  logic              jump,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              align_err,
   output logic [31:0]       retire_cnt
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] instr_q;
   logic              instr_valid_q, instr_valid_d;
   logic              align_err_q, align_err_d;
   logic [31:0]       retire_cnt_q;
   logic              retire_inc;
   logic              instr_load;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] target;

   pc_reg #(
      .WIDTH     (ADDR_W),
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .load  (pc_load),
      .d     (pc_next),
      .q     (pc)
   );

   always_comb begin
      if (jump) begin
         target = jump_target;
      end else if (branch_taken) begin
         target = branch_target;
      end else begin
         target = pc + ADDR_W'(PC_STEP);
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_load       = 1'b0;
      pc_next       = pc;
      instr_load    = 1'b0;
      instr_valid_d = 1'b0;
      align_err_d   = align_err_q;
      retire_inc    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            if (imem_ack) begin
               instr_load    = 1'b1;
               instr_valid_d = 1'b1;
               state_d       = StExec;
            end
         end
         StExec: begin
            if (exec_done) begin
               retire_inc = 1'b1;
               if (halt_req) begin
                  state_d = StHalt;
               end else if ((jump || branch_taken) && (target[1:0] != 2'b00)) begin
                  // Misaligned control-flow target: keep the PC of the offending instruction
                  align_err_d = 1'b1;
                  state_d     = StHalt;
               end else begin
                  pc_load = 1'b1;
                  pc_next = target;
                  state_d = StFetch;
               end
            end
         end
         StHalt: begin
            if (start) begin
               pc_load     = 1'b1;
               pc_next     = RESET_PC;
               align_err_d = 1'b0;
               state_d     = StFetch;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         align_err_q   <= 1'b0;
         retire_cnt_q  <= '0;
      end else begin
         state_q       <= state_d;
         instr_valid_q <= instr_valid_d;
         align_err_q   <= align_err_d;
         if (instr_load) instr_q <= imem_rdata;
         if (retire_inc) retire_cnt_q <= retire_cnt_q + 32'd1;
      end
   end

   assign imem_req    = (state_q == StFetch);
   assign imem_addr   = pc;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign halted      = (state_q == StHalt);
   assign align_err   = align_err_q;
   assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; fetched words are scoreboarded against instr_valid pulses.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        exec_done = 1'b0;
   logic        halt_req = 1'b0;
   logic        jump = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] jump_target = '0;
   logic [31:0] branch_target = '0;
   logic [31:0] pc;
   logic        halted;
   logic        align_err;
   logic [31:0] retire_cnt;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] word;
      logic [31:0] addr;
   } exp_t;
   exp_t exp_q[$];

   pc_sequencer u_dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .exec_done     (exec_done),
      .halt_req      (halt_req),
      .jump          (jump),
      .branch_taken  (branch_taken),
      .jump_target   (jump_target),
      .branch_target (branch_target),
      .pc            (pc),
      .halted        (halted),
      .align_err     (align_err),
      .retire_cnt    (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every instr_valid pulse must match the oldest outstanding fetch.
   always @(negedge clk) begin
      if (reset && instr_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_instr_valid: got instr %h expected no pulse", instr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("instr", instr, e.word);
            check("instr_pc", pc, e.addr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Expects FETCH on entry; holds off the ack for wait_cycles while checking imem_req.
   task automatic fetch(input logic [31:0] word, input logic [31:0] addr, input int wait_cycles);
      for (int i = 0; i < wait_cycles; i++) begin
         check("imem_req_wait", {31'd0, imem_req}, 32'd1);
         check("imem_addr", imem_addr, addr);
         step();
      end
      check("imem_req_at_ack", {31'd0, imem_req}, 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = word;
      exp_q.push_back('{word: word, addr: addr});
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'hxxxx_xxxx;
   endtask

   task automatic exec(input logic h, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt);
      exec_done     = 1'b1;
      halt_req      = h;
      jump          = j;
      jump_target   = jt;
      branch_taken  = b;
      branch_target = bt;
      step();
      exec_done     = 1'b0;
      halt_req      = 1'b0;
      jump          = 1'b0;
      branch_taken  = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_pc", pc, 32'h0);
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_align", {31'd0, align_err}, 32'd0);
      check("rst_retire", retire_cnt, 32'd0);
      check("rst_instr", instr, 32'd0);
      reset = 1'b1;
      step();
      check("idle_imem_req", {31'd0, imem_req}, 32'd0);

      // Sequential stepping
      do_start();
      check("start_imem_req", {31'd0, imem_req}, 32'd1);
      check("start_pc", pc, 32'h0);
      fetch(32'h1111_1111, 32'h0, 0);
      exec(0, 0, 0, 0, 0);
      check("seq_pc1", pc, 32'h4);
      check("seq_req1", {31'd0, imem_req}, 32'd1);
      fetch(32'h2222_2222, 32'h4, 0);
      exec(0, 0, 0, 0, 0);
      check("seq_pc2", pc, 32'h8);
      fetch(32'h3333_3333, 32'h8, 0);
      exec(0, 0, 0, 0, 0);
      check("seq_pc3", pc, 32'hC);
      check("seq_retire", retire_cnt, 32'd3);

      // Wait states, then spurious ack/start in EXEC
      fetch(32'hA5A5_0001, 32'hC, 3);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      start      = 1'b1;
      step();
      imem_ack   = 1'b0;
      start      = 1'b0;
      check("spur_exec_pc", pc, 32'hC);
      check("spur_exec_retire", retire_cnt, 32'd3);
      check("spur_exec_req", {31'd0, imem_req}, 32'd0);
      check("spur_exec_instr", instr, 32'hA5A5_0001);
      check("spur_exec_valid", {31'd0, instr_valid}, 32'd0);

      // Priority: jump over branch, then halt over both
      exec(0, 1, 32'h100, 1, 32'h200);
      check("prio_jump_pc", pc, 32'h100);
      check("prio_retire", retire_cnt, 32'd4);
      fetch(32'h4444_4444, 32'h100, 0);
      exec(1, 1, 32'h300, 1, 32'h200);
      check("prio_halt_pc", pc, 32'h100);
      check("prio_halted", {31'd0, halted}, 32'd1);
      check("prio_halt_req", {31'd0, imem_req}, 32'd0);
      check("prio_halt_align", {31'd0, align_err}, 32'd0);
      check("prio_halt_retire", retire_cnt, 32'd5);
      do_start();
      check("restart_pc", pc, 32'h0);
      check("restart_halted", {31'd0, halted}, 32'd0);
      check("restart_req", {31'd0, imem_req}, 32'd1);
      check("restart_retire", retire_cnt, 32'd5);

      // Wrap and alignment
      fetch(32'h5555_5555, 32'h0, 0);
      exec(0, 0, 0, 1, 32'hFFFF_FFFC);
      check("branch_pc", pc, 32'hFFFF_FFFC);
      fetch(32'h6666_6666, 32'hFFFF_FFFC, 0);
      exec(0, 0, 0, 0, 0);
      check("wrap_pc", pc, 32'h0);
      fetch(32'h7777_7777, 32'h0, 0);
      exec(0, 1, 32'h102, 0, 0);
      check("misalign_halted", {31'd0, halted}, 32'd1);
      check("misalign_err", {31'd0, align_err}, 32'd1);
      check("misalign_pc", pc, 32'h0);
      check("misalign_retire", retire_cnt, 32'd8);
      do_start();
      check("clr_align", {31'd0, align_err}, 32'd0);
      check("clr_pc", pc, 32'h0);

      // Advance PC, then spurious exec_done in FETCH
      fetch(32'h8888_8888, 32'h0, 0);
      exec(0, 0, 0, 0, 0);
      check("pre_rst_pc", pc, 32'h4);
      exec(0, 1, 32'h40, 0, 0);
      check("spur_fetch_pc", pc, 32'h4);
      check("spur_fetch_retire", retire_cnt, 32'd9);
      check("spur_fetch_req", {31'd0, imem_req}, 32'd1);

      // Asynchronous reset in FETCH, away from any clock edge
      #2;
      reset = 1'b0;
      #1;
      check("async_req", {31'd0, imem_req}, 32'd0);
      check("async_pc", pc, 32'h0);
      check("async_retire", retire_cnt, 32'd0);
      #1;
      reset = 1'b1;
      step();
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      step();
      imem_ack   = 1'b0;
      check("late_ack_req", {31'd0, imem_req}, 32'd0);
      check("late_ack_instr", instr, 32'h0);
      check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
      exec(0, 1, 32'h80, 0, 0);
      check("idle_done_pc", pc, 32'h0);
      check("idle_done_retire", retire_cnt, 32'd0);
      check("idle_done_req", {31'd0, imem_req}, 32'd0);

      // Recovery after reset
      do_start();
      fetch(32'h9999_9999, 32'h0, 1);
      exec(0, 0, 0, 0, 0);
      check("recover_pc", pc, 32'h4);
      check("recover_retire", retire_cnt, 32'd1);

      step();
      step();
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
